// File: rtl/norm_shift_seq.sv
// rtl/norm_shift_seq.sv - sequential post-add/sub mantissa normalizer
//
// Left-shifts an unnormalized mantissa by up to STEP bits per cycle until its
// MSB is set. The exponent is decremented by the same amount on each step.
// Zero results and results that hit the exponent floor (denormals) are flagged.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   in_valid / in_ready              operand handshake (ready only in IDLE)
//   in_mant, in_exp, in_sign         unnormalized operand
//   out_valid / out_ready            result handshake (valid only in DONE)
//   out_mant, out_exp, out_sign      normalized (or denormal) result
//   out_zero, out_underflow          result flags
module norm_shift_seq #(
    parameter int MANT_W = 24,
    parameter int EXP_W  = 8,
    parameter int STEP   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [MANT_W-1:0] in_mant,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic              in_sign,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [MANT_W-1:0] out_mant,
    output logic [EXP_W-1:0]  out_exp,
    output logic              out_sign,
    output logic              out_zero,
    output logic              out_underflow
);

    localparam int CW = $clog2(STEP + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [MANT_W-1:0] mant_q, mant_d;
    logic [EXP_W-1:0]  exp_q, exp_d;
    logic              sign_q, sign_d;
    logic              zero_q, zero_d;
    logic              uf_q, uf_d;

    logic [CW-1:0]     lzw;
    logic              found;
    logic [EXP_W-1:0]  exp_m1;
    logic [EXP_W-1:0]  shamt;

    // Leading zeros within the top STEP bits only, saturating at STEP.
    always_comb begin
        lzw   = '0;
        found = 1'b0;
        for (int i = 0; i < STEP; i++) begin
            if (!found) begin
                if (mant_q[MANT_W-1-i]) begin
                    found = 1'b1;
                end else begin
                    lzw = lzw + CW'(1);
                end
            end
        end
    end

    // Shift is clamped to exp-1 so the exponent bottoms out at 1, never wraps.
    // Only used when exp_q >= 2, so exp_m1 is always meaningful there.
    always_comb begin
        exp_m1 = exp_q - EXP_W'(1);
        shamt  = (EXP_W'(lzw) < exp_m1) ? EXP_W'(lzw) : exp_m1;
    end

    always_comb begin
        state_d = state_q;
        mant_d  = mant_q;
        exp_d   = exp_q;
        sign_d  = sign_q;
        zero_d  = zero_q;
        uf_d    = uf_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mant_d  = in_mant;
                    exp_d   = in_exp;
                    sign_d  = in_sign;
                    zero_d  = 1'b0;
                    uf_d    = 1'b0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (mant_q == '0) begin
                    exp_d   = '0;
                    zero_d  = 1'b1;
                    uf_d    = 1'b0;
                    state_d = DONE;
                end else if (mant_q[MANT_W-1]) begin
                    zero_d  = 1'b0;
                    uf_d    = 1'b0;
                    state_d = DONE;
                end else if (exp_q <= EXP_W'(1)) begin
                    exp_d   = '0;
                    zero_d  = 1'b0;
                    uf_d    = 1'b1;
                    state_d = DONE;
                end else begin
                    mant_d = mant_q << shamt;
                    exp_d  = exp_q - shamt;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mant_q  <= '0;
            exp_q   <= '0;
            sign_q  <= 1'b0;
            zero_q  <= 1'b0;
            uf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            mant_q  <= mant_d;
            exp_q   <= exp_d;
            sign_q  <= sign_d;
            zero_q  <= zero_d;
            uf_q    <= uf_d;
        end
    end

    assign in_ready      = (state_q == IDLE);
    assign out_valid     = (state_q == DONE);
    assign out_mant      = mant_q;
    assign out_exp       = exp_q;
    assign out_sign      = sign_q;
    assign out_zero      = zero_q;
    assign out_underflow = uf_q;

endmodule

// File: tb/tb_norm_shift_seq.sv
// tb/tb_norm_shift_seq.sv - self-checking bench for norm_shift_seq
module tb_norm_shift_seq;

    localparam int MANT_W = 24;
    localparam int EXP_W  = 8;
    localparam int STEP   = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [MANT_W-1:0] in_mant;
    logic [EXP_W-1:0]  in_exp;
    logic              in_sign;
    logic              out_valid;
    logic              out_ready;
    logic [MANT_W-1:0] out_mant;
    logic [EXP_W-1:0]  out_exp;
    logic              out_sign;
    logic              out_zero;
    logic              out_underflow;

    int n_cmp  = 0;
    int n_fail = 0;

    norm_shift_seq #(.MANT_W(MANT_W), .EXP_W(EXP_W), .STEP(STEP)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_mant(in_mant), .in_exp(in_exp), .in_sign(in_sign),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_mant(out_mant), .out_exp(out_exp), .out_sign(out_sign),
        .out_zero(out_zero), .out_underflow(out_underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference: total shift is min(lz, exp-1); shifting proceeds STEP bits a
    // cycle, plus one accept cycle and one final evaluation cycle.
    task automatic model(input logic [MANT_W-1:0] m, input logic [EXP_W-1:0] e,
                         output logic [MANT_W-1:0] rm, output logic [EXP_W-1:0] re,
                         output logic rz, output logic ru, output int lat);
        int lz;
        lz = 0;
        while (lz < MANT_W && m[MANT_W-1-lz] == 1'b0) lz++;
        rm = m; re = e; rz = 1'b0; ru = 1'b0; lat = 2;
        if (m == 0) begin
            re = 0; rz = 1'b1;
        end else if (lz == 0) begin
            // already normalized
        end else if (e <= 1) begin
            re = 0; ru = 1'b1;
        end else if (lz <= int'(e) - 1) begin
            rm  = m << lz;
            re  = e - EXP_W'(lz);
            lat = 2 + (lz + STEP - 1) / STEP;
        end else begin
            rm  = m << (int'(e) - 1);
            re  = 0;
            ru  = 1'b1;
            lat = 2 + (int'(e) - 1 + STEP - 1) / STEP;
        end
    endtask

    // One full operation; hold = cycles of out_ready backpressure after valid.
    task automatic op(input logic [MANT_W-1:0] m, input logic [EXP_W-1:0] e,
                      input logic sg, input int hold);
        logic [MANT_W-1:0] rm;
        logic [EXP_W-1:0]  re;
        logic              rz, ru;
        int                lat, n;
        model(m, e, rm, re, rz, ru, lat);
        @(negedge clk);
        out_ready = (hold == 0);
        in_mant = m; in_exp = e; in_sign = sg; in_valid = 1'b1;
        chk("in_ready_idle", in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (out_valid) break;
            chk("in_ready_busy", in_ready, 0);
        end
        chk("out_valid_seen", out_valid, 1);
        chk("latency", n, lat);
        chk("out_mant", out_mant, rm);
        chk("out_exp", out_exp, re);
        chk("out_sign", out_sign, sg);
        chk("out_zero", out_zero, rz);
        chk("out_underflow", out_underflow, ru);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            in_mant  = MANT_W'($urandom);
            in_exp   = EXP_W'($urandom);
            @(negedge clk);
            chk("bp_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_mant", out_mant, rm);
            chk("bp_exp", out_exp, re);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("ready_after_hs", in_ready, 1);
        chk("valid_after_hs", out_valid, 0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_mant = '0; in_exp = '0; in_sign = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_mant", out_mant, 0);
        chk("rst_exp", out_exp, 0);
        chk("rst_flags", {out_sign, out_zero, out_underflow}, 0);
        rst_n = 1'b1;

        op(24'h800000, 8'h7F, 1'b0, 0);
        op(24'h040000, 8'h80, 1'b0, 0);
        op(24'h000001, 8'h7F, 1'b0, 0);
        op(24'h000100, 8'h05, 1'b0, 0);
        op(24'h000000, 8'h55, 1'b1, 0);
        op(24'h040000, 8'h80, 1'b1, 5);
        op(24'h000003, 8'h00, 1'b0, 0);
        op(24'h000010, 8'h14, 1'b0, 0);

        // Reset in the middle of a long normalization.
        @(negedge clk);
        in_mant = 24'h000001; in_exp = 8'h7F; in_sign = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst_busy", in_ready, 0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_mant", out_mant, 0);
        chk("mid_rst_exp", out_exp, 0);
        chk("mid_rst_flags", {out_sign, out_zero, out_underflow}, 0);
        chk("mid_rst_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("no_stale_valid", out_valid, 0);
            chk("post_rst_ready", in_ready, 1);
        end

        for (int k = 0; k < 60; k++) begin
            int                lz;
            logic [MANT_W-1:0] m;
            logic [EXP_W-1:0]  e;
            lz = $urandom_range(0, MANT_W);
            if (lz == MANT_W) m = '0;
            else m = (MANT_W'($urandom) >> lz) | (24'h800000 >> lz);
            if ($urandom_range(0, 1) == 1) e = EXP_W'($urandom_range(0, 20));
            else e = EXP_W'($urandom_range(0, 255));
            op(m, e, 1'($urandom), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
